// File: rtl/req_capture.sv
// Request conditioning ahead of the 4-to-2 priority encoder: optional sync, per-bit debounce,
// rising-edge capture into sticky pending bits, ack clearing and miss tracking. Optional: `SYNC_EN.
module req_capture #(
  parameter int unsigned N         = 4,
  parameter int unsigned IW        = 2,
  parameter int unsigned DB_CYCLES = 3,
  parameter int unsigned CW        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_in,
  input  logic          ack,
  input  logic [IW-1:0] ack_idx,
  input  logic          miss_clr,
  output logic [N-1:0]  pend,
  output logic          any_pend,
  output logic [N-1:0]  miss
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [N-1:0]  raw;
  logic [N-1:0]  stb;
  logic [N-1:0]  stb_d;
  logic [N-1:0]  rise;
  logic [N-1:0]  ack_hit;
  logic [CW-1:0] cnt [N];

`ifdef SYNC_EN
  // Two-flop synchroniser per request line
  logic [N-1:0] sync_q1;
  logic [N-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= req_in;
      sync_q2 <= sync_q1;
    end
  end

  assign raw = sync_q2;
`else
  assign raw = req_in;
`endif

  // A changed level must hold DB_CYCLES consecutive edges; any bounce back restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      stb <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (raw[i] == stb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stb[i] <= raw[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // One-hot decode of the serviced index
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < N; i++) ack_hit[i] = ack && (ack_idx == IW'(i));
  end

  assign rise = stb & ~stb_d;

  // New edges win over a same-edge ack or miss_clr so nothing is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_d <= '0;
      pend  <= '0;
      miss  <= '0;
    end else begin
      stb_d <= stb;
      pend  <= rise | (pend & ~ack_hit);
      miss  <= (rise & pend & ~ack_hit) | (miss & ~{N{miss_clr}});
    end
  end

  assign any_pend = |pend;

endmodule
